noc_inject_scheduler: RTL and testbench



---
 rtl/noc_inject_scheduler.sv | 174 +++++++++++++++++
 tb/tb_noc_inject_scheduler.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_inject_scheduler.sv
// Injection scheduler for one CONNECT send port: round-robin packet arbitration
// with a wormhole lock, per-VC credit tracking and a registered flit output.
module noc_inject_scheduler #(
  parameter int NUM_REQ = 2,
  parameter int NUM_VCS = 2,
  parameter int VC_W    = 1,
  parameter int DEST_W  = 5,
  parameter int DATA_W  = 32,
  parameter int CREDITS = 8,
  parameter int CNT_W   = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0]              req_tail,
  input  logic [NUM_REQ*DEST_W-1:0]       req_dest,
  input  logic [NUM_REQ*DATA_W-1:0]       req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [2+DATA_W+DEST_W+VC_W-1:0] flit_out,
  output logic                            flit_out_en,
  input  logic [VC_W:0]                   credit_in,
  output logic [NUM_VCS*CNT_W-1:0]        credit_cnt,
  output logic                            busy,
  output logic                            credit_err
);

  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int FLIT_W = 2 + DATA_W + DEST_W + VC_W;

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } state_e;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]    owner_q, owner_d;
  logic [CNT_W-1:0]    credit_q [NUM_VCS];
  logic [CNT_W-1:0]    credit_d [NUM_VCS];
  logic                credit_err_q, credit_err_d;
  logic [FLIT_W-1:0]   flit_q, flit_d;
  logic                flit_en_q, flit_en_d;

  logic [NUM_REQ-1:0]  eligible;
  logic                grant_found;
  logic [PTR_W-1:0]    grant_idx;
  logic                accept;
  int                  cand;
  logic [NUM_VCS-1:0]  inc_vc;
  logic [NUM_VCS-1:0]  dec_vc;

  function automatic logic [VC_W-1:0] vc_of(input int r);
    return VC_W'(r % NUM_VCS);
  endfunction

  // NOTE: every signal written in a combinational block gets a default first,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    eligible = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      eligible[r] = req_valid[r] && (credit_q[r % NUM_VCS] != '0);
    end
  end

  // While locked only the owner may advance; otherwise search circularly from rr_ptr.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    if (state_q == ST_LOCKED) begin
      grant_found = eligible[owner_q];
      grant_idx   = owner_q;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cand = (int'(rr_ptr_q) + i) % NUM_REQ;
        if (!grant_found && eligible[cand]) begin
          grant_found = 1'b1;
          grant_idx   = PTR_W'(cand);
        end
      end
    end
  end

  assign accept = grant_found && !reset;

  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    flit_d   = '0;
    flit_en_d = 1'b0;
    if (accept) begin
      flit_en_d = 1'b1;
      flit_d    = {1'b1, req_tail[grant_idx],
                   req_dest[grant_idx*DEST_W +: DEST_W],
                   vc_of(int'(grant_idx)),
                   req_data[grant_idx*DATA_W +: DATA_W]};
      if (req_tail[grant_idx]) begin
        state_d  = ST_IDLE;
        rr_ptr_d = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
      end else begin
        state_d = ST_LOCKED;
        owner_d = grant_idx;
      end
    end
  end

  // A return and a send on the same VC cancel; a return onto a full VC is an error.
  always_comb begin
    credit_err_d = credit_err_q;
    inc_vc       = '0;
    dec_vc       = '0;
    for (int v = 0; v < NUM_VCS; v++) begin
      inc_vc[v]   = credit_in[VC_W] && (credit_in[VC_W-1:0] == VC_W'(v));
      dec_vc[v]   = accept && (vc_of(int'(grant_idx)) == VC_W'(v));
      credit_d[v] = credit_q[v];
      if (inc_vc[v] && !dec_vc[v]) begin
        if (credit_q[v] == CNT_W'(CREDITS)) begin
          credit_err_d = 1'b1;
        end else begin
          credit_d[v] = credit_q[v] + CNT_W'(1);
        end
      end else if (dec_vc[v] && !inc_vc[v]) begin
        credit_d[v] = credit_q[v] - CNT_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      credit_err_q <= 1'b0;
      flit_q       <= '0;
      flit_en_q    <= 1'b0;
      for (int v = 0; v < NUM_VCS; v++) begin
        credit_q[v] <= CNT_W'(CREDITS);
      end
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      credit_err_q <= credit_err_d;
      flit_q       <= flit_d;
      flit_en_q    <= flit_en_d;
      for (int v = 0; v < NUM_VCS; v++) begin
        credit_q[v] <= credit_d[v];
      end
    end
  end

  always_comb begin
    credit_cnt = '0;
    for (int v = 0; v < NUM_VCS; v++) begin
      credit_cnt[v*CNT_W +: CNT_W] = credit_q[v];
    end
  end

  assign flit_out    = flit_q;
  assign flit_out_en = flit_en_q;
  assign busy        = (state_q == ST_LOCKED);
  assign credit_err  = credit_err_q;

endmodule

// File: tb/tb_noc_inject_scheduler.sv
// Bench for noc_inject_scheduler: a packet-level model checked every cycle plus
// directed vectors with hand-computed grants and credit counts.
module tb_noc_inject_scheduler;

  localparam int NR      = 2;
  localparam int NV      = 2;
  localparam int VC_W    = 1;
  localparam int DEST_W  = 5;
  localparam int DATA_W  = 32;
  localparam int CREDITS = 8;
  localparam int CNT_W   = 4;
  localparam int FLIT_W  = 2 + DATA_W + DEST_W + VC_W;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NR-1:0]          req_valid;
  logic [NR-1:0]          req_tail;
  logic [NR*DEST_W-1:0]   req_dest;
  logic [NR*DATA_W-1:0]   req_data;
  logic [NR-1:0]          req_ready;
  logic [FLIT_W-1:0]      flit_out;
  logic                   flit_out_en;
  logic [VC_W:0]          credit_in;
  logic [NV*CNT_W-1:0]    credit_cnt;
  logic                   busy;
  logic                   credit_err;

  int n_cmp = 0;
  int n_err = 0;
  int seq   = 0;

  noc_inject_scheduler #(
    .NUM_REQ(NR), .NUM_VCS(NV), .VC_W(VC_W), .DEST_W(DEST_W),
    .DATA_W(DATA_W), .CREDITS(CREDITS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_tail(req_tail), .req_dest(req_dest), .req_data(req_data),
    .req_ready(req_ready),
    .flit_out(flit_out), .flit_out_en(flit_out_en),
    .credit_in(credit_in), .credit_cnt(credit_cnt),
    .busy(busy), .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Packet-level reference: owner = -1 means no packet in flight.
  int              m_cred [NV];
  int              m_owner;
  int              m_rr;
  bit              m_err;
  bit              m_fen;
  logic [FLIT_W-1:0] m_flit;
  bit              m_known = 1'b0;
  int              g;
  int              r_c;
  logic [NR-1:0]   exp_rdy;

  always @(negedge clk) begin
    g = -1;
    if (!reset && m_known) begin
      if (m_owner >= 0) begin
        if (req_valid[m_owner] && m_cred[m_owner % NV] > 0) g = m_owner;
      end else begin
        for (int k = 0; k < NR; k++) begin
          r_c = (m_rr + k) % NR;
          if (g < 0 && req_valid[r_c] && m_cred[r_c % NV] > 0) g = r_c;
        end
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;

    if (m_known) begin
      check("req_ready",   64'(req_ready),   64'(exp_rdy));
      check("flit_out_en", 64'(flit_out_en), 64'(m_fen));
      check("flit_out",    64'(flit_out),    64'(m_flit));
      check("busy",        64'(busy),        64'(m_owner >= 0));
      check("credit_vc0",  64'(credit_cnt[3:0]), 64'(m_cred[0]));
      check("credit_vc1",  64'(credit_cnt[7:4]), 64'(m_cred[1]));
      check("credit_err",  64'(credit_err),  64'(m_err));
    end

    if (reset) begin
      m_known = 1'b1;
      m_owner = -1;
      m_rr    = 0;
      m_cred  = '{default: CREDITS};
      m_err   = 1'b0;
      m_fen   = 1'b0;
      m_flit  = '0;
    end else if (m_known) begin
      m_fen  = (g >= 0);
      m_flit = '0;
      if (g >= 0) begin
        m_flit = {1'b1, req_tail[g], req_dest[g*DEST_W +: DEST_W], VC_W'(g % NV),
                  req_data[g*DATA_W +: DATA_W]};
        m_cred[g % NV] = m_cred[g % NV] - 1;
        if (req_tail[g]) begin
          m_owner = -1;
          m_rr    = (g + 1) % NR;
        end else begin
          m_owner = g;
        end
      end
      if (credit_in[VC_W]) begin
        if (m_cred[int'(credit_in[0])] >= CREDITS) m_err = 1'b1;
        else m_cred[int'(credit_in[0])] = m_cred[int'(credit_in[0])] + 1;
      end
    end
  end

  // Inputs change 2 time units after the rising edge; ready is checked 1 unit later.
  task automatic step(input logic [1:0] v, input logic [1:0] t, input logic [1:0] cr,
                      input logic [1:0] exp_ready, input string nm);
    seq++;
    req_valid = v;
    req_tail  = t;
    credit_in = cr;
    req_data  = {32'hB000_0000 + 32'(seq), 32'hA000_0000 + 32'(seq)};
    #1;
    check(nm, 64'(req_ready), 64'(exp_ready));
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    req_tail  = '0;
    credit_in = '0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  logic [FLIT_W-1:0] exp_flit1;

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_tail  = '0;
    req_dest  = {5'd20, 5'd7};
    req_data  = '0;
    credit_in = '0;
    repeat (3) @(posedge clk);
    #2;
    // Reset values, with requests pending while reset is still held.
    req_valid = 2'b11;
    #1;
    check("rst_ready",  64'(req_ready),   64'h0);
    check("rst_en",     64'(flit_out_en), 64'h0);
    check("rst_flit",   64'(flit_out),    64'h0);
    check("rst_busy",   64'(busy),        64'h0);
    check("rst_credit", 64'(credit_cnt),  64'h88);
    check("rst_err",    64'(credit_err),  64'h0);

    // Single-flit packet from r0.
    reset     = 1'b0;
    req_valid = 2'b01;
    req_tail  = 2'b01;
    req_data  = {32'h0, 32'h0000_00A5};
    #1;
    check("t1_ready", 64'(req_ready), 64'h1);
    @(posedge clk);
    #2;
    exp_flit1 = {1'b1, 1'b1, 5'd7, 1'b0, 32'h0000_00A5};
    check("t1_flit", 64'(flit_out),        64'(exp_flit1));
    check("t1_en",   64'(flit_out_en),     64'h1);
    check("t1_vc0",  64'(credit_cnt[3:0]), 64'd7);

    // Wormhole lock, then per-packet alternation (rr_ptr starts at 1 here).
    step(2'b01, 2'b00, 2'b00, 2'b01, "t2_r0_head");
    check("t2_busy_lock", 64'(busy), 64'h1);
    step(2'b11, 2'b00, 2'b00, 2'b01, "t2_r0_body");
    step(2'b11, 2'b01, 2'b00, 2'b01, "t2_r0_tail");
    check("t2_busy_free", 64'(busy), 64'h0);
    step(2'b11, 2'b00, 2'b00, 2'b10, "t2_r1_head");
    step(2'b11, 2'b10, 2'b00, 2'b10, "t2_r1_tail");
    step(2'b11, 2'b01, 2'b00, 2'b01, "t2_r0_single");
    step(2'b11, 2'b10, 2'b00, 2'b10, "t2_r1_single");
    step(2'b11, 2'b00, 2'b00, 2'b01, "t2_r0_head2");
    step(2'b11, 2'b01, 2'b00, 2'b01, "t2_r0_tail2");
    step(2'b11, 2'b10, 2'b00, 2'b10, "t2_r1_single2");
    check("t2_vc0", 64'(credit_cnt[3:0]), 64'd1);
    check("t2_vc1", 64'(credit_cnt[7:4]), 64'd4);

    // Credit exhaustion on VC0 and recovery by a single return.
    do_reset();
    for (int i = 0; i < 8; i++) step(2'b01, 2'b01, 2'b00, 2'b01, "t3_send");
    check("t3_vc0_empty", 64'(credit_cnt[3:0]), 64'd0);
    step(2'b01, 2'b01, 2'b10, 2'b00, "t3_starved");
    step(2'b01, 2'b01, 2'b00, 2'b01, "t3_after_ret");
    check("t3_vc0_again", 64'(credit_cnt[3:0]), 64'd0);
    step(2'b00, 2'b00, 2'b00, 2'b00, "t3_idle");

    // Locked owner out of credits blocks r1 until its tail goes out.
    do_reset();
    step(2'b01, 2'b00, 2'b00, 2'b01, "t4_head");
    for (int i = 0; i < 7; i++) step(2'b01, 2'b00, 2'b00, 2'b01, "t4_body");
    for (int i = 0; i < 3; i++) step(2'b11, 2'b11, 2'b00, 2'b00, "t4_blocked");
    check("t4_busy", 64'(busy), 64'h1);
    step(2'b11, 2'b11, 2'b10, 2'b00, "t4_return");
    step(2'b11, 2'b11, 2'b00, 2'b01, "t4_owner_tail");
    step(2'b10, 2'b11, 2'b00, 2'b10, "t4_r1_go");
    step(2'b00, 2'b00, 2'b00, 2'b00, "t4_idle");

    // Overflow on a full VC, then simultaneous send and return on VC0.
    do_reset();
    step(2'b00, 2'b00, 2'b11, 2'b00, "t5_overflow");
    check("t5_vc1_sat", 64'(credit_cnt[7:4]), 64'd8);
    check("t5_err",     64'(credit_err),      64'h1);
    step(2'b00, 2'b00, 2'b00, 2'b00, "t5_idle");
    step(2'b00, 2'b00, 2'b00, 2'b00, "t5_idle");
    check("t5_err_sticky", 64'(credit_err), 64'h1);
    step(2'b01, 2'b01, 2'b00, 2'b01, "t5_send");
    step(2'b01, 2'b01, 2'b10, 2'b01, "t5_send_ret");
    check("t5_vc0_same", 64'(credit_cnt[3:0]), 64'd7);

    // Reset in the middle of a packet.
    step(2'b01, 2'b00, 2'b00, 2'b01, "t6_head");
    reset     = 1'b1;
    req_valid = 2'b11;
    req_tail  = 2'b00;
    #1;
    check("t6_rst_ready", 64'(req_ready), 64'h0);
    @(posedge clk);
    #2;
    check("t6_busy",   64'(busy),        64'h0);
    check("t6_en",     64'(flit_out_en), 64'h0);
    check("t6_credit", 64'(credit_cnt),  64'h88);
    check("t6_err",    64'(credit_err),  64'h0);
    reset = 1'b0;
    step(2'b01, 2'b01, 2'b00, 2'b01, "t6_restart");
    step(2'b00, 2'b00, 2'b00, 2'b00, "t6_idle");

    @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
